fabric_tag_demux: RTL
=====================

FABRIC_TAG_DEMUX -- requirements
Module: fabric_tag_demux

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL be the payload width excluding the tag.
REQ-002 Parameter TAG_WIDTH, default 2, SHALL be the input tag width.
REQ-003 Parameter NUM_OUT, default 4, SHALL be the number of output ports; legal range is 1..2^TAG_WIDTH.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; every flop is rising-edge clk.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit, SHALL mark a valid tagged input beat.
REQ-007 Port in_ready, output, 1 bit, SHALL indicate that the input beat is accepted.
REQ-008 Port in_data, input, DATA_WIDTH+TAG_WIDTH bits, SHALL carry {tag, value}, with the tag in the upper bits.
REQ-009 Ports out_valid and out_ready, NUM_OUT bits each, SHALL carry per-output handshakes.
REQ-010 Port out_data, output, NUM_OUT x DATA_WIDTH bits, SHALL carry the untagged per-output values.
REQ-011 Port cfg_data, input, NUM_OUT bits, SHALL hold the per-output enable mask.
REQ-012 Ports error_valid (1 bit) and error_code (16 bits), outputs, SHALL report the latched error.

Function
REQ-013 The tag t SHALL equal in_data[DATA_WIDTH +: TAG_WIDTH], and the value SHALL equal in_data[DATA_WIDTH-1:0].
REQ-014 Each output SHALL own a 2-entry FIFO holding value only, with the tag stripped.
REQ-015 A beat with t < NUM_OUT and cfg_data[t]=1 SHALL be routed; in_ready SHALL then equal !full[t].
- full[t] is taken from registered state only.
- A pop in the same cycle does not make room for a push.
REQ-016 A beat with t >= NUM_OUT or cfg_data[t]=0 SHALL be dropped; in_ready SHALL be 1 so the beat is consumed and the stream does not deadlock.
REQ-017 A routed beat accepted in cycle N SHALL appear on out_valid[t] in cycle N+1 if FIFO[t] was empty; this is 1-cycle latency.
REQ-018 out_valid[i] SHALL be !empty[i], and out_data[i] SHALL be the FIFO[i] head.
- A pop occurs on out_valid[i] && out_ready[i].
- Simultaneous push and pop on a non-full FIFO SHALL keep its occupancy unchanged.
REQ-019 Per-output order SHALL be preserved; there is no ordering across outputs.
REQ-020 An output whose FIFO is full SHALL stall only beats tagged for it, with head-of-line blocking on the input.
REQ-021 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
- Occupancy is a 2-bit counter with values 0..2.
REQ-022 A cfg_data change SHALL affect acceptance only; already-buffered entries still drain.
REQ-023 Error codes SHALL be drawn from the shared package.
- RT_TAG_DEMUX_RANGE: t >= NUM_OUT with in_valid.
- RT_TAG_DEMUX_DISABLED: a disabled output is tagged with in_valid.
- If both conditions hold, RANGE wins.
REQ-024 The first error SHALL be latched on the next rising clk edge and held until reset; later errors SHALL be ignored, and dropping SHALL continue.

Reset
REQ-025 With rst_n low, all FIFOs SHALL empty immediately, so out_valid=0 asynchronously; error_valid=0 and error_code=0.
REQ-026 in_ready SHALL be 0 while rst_n is low.
REQ-027 A reset during traffic SHALL discard buffered data without emitting partial beats.

Configuration
REQ-028 Macro FABRIC_TAG_DEMUX_PERF_EN, when defined, SHALL add performance counters.
- Output perf_out_count: NUM_OUT x 32 bits, counting out handshakes per port.
- Output perf_drop_count: 32 bits, counting dropped beats.
- Both wrap modulo 2^32 and reset to 0.
REQ-029 When FABRIC_TAG_DEMUX_PERF_EN is undefined, those ports and counters SHALL be absent, and function SHALL be otherwise identical.

Structure
REQ-030 Error codes RT_TAG_DEMUX_RANGE and RT_TAG_DEMUX_DISABLED SHALL reside in the shared fabric common package/header.
REQ-031 The per-output FIFO SHALL be a sub-module fabric_tag_demux_fifo (parameter DATA_WIDTH, depth 2), instantiated NUM_OUT times via generate.
REQ-032 Elaboration SHALL $fatal when DATA_WIDTH<1, TAG_WIDTH<1, NUM_OUT<1, or NUM_OUT>2^TAG_WIDTH.

Verification
REQ-033 Test 1, routing and latency.
- Stimulus: NUM_OUT=4, cfg=4'b1111; in tag=2, value=0xDEADBEEF, all out_ready=1.
- Response: out_valid[2]=1 and out_data[2]=0xDEADBEEF exactly 1 cycle later; other outputs stay 0.
REQ-034 Test 2, back-pressure.
- Stimulus: out_ready[1]=0; three beats tagged 1 (values 1, 2, 3).
- Response: first two accepted, in_ready=0 on the third; after out_ready[1]=1, outputs 1, 2, 3 appear in order.
REQ-035 Test 3, disabled output.
- Stimulus: cfg=4'b1011; beat tag=2.
- Response: in_ready=1, no out_valid; next cycle error_valid=1 and error_code=RT_TAG_DEMUX_DISABLED.
REQ-036 Test 4, out-of-range tag.
- Stimulus: NUM_OUT=3, TAG_WIDTH=2; beat tag=3.
- Response: dropped; error_code=RT_TAG_DEMUX_RANGE; a subsequent disabled-tag beat leaves the code unchanged.
REQ-037 Test 5, reset mid-operation.
- Stimulus: fill FIFO 0 with 2 entries, assert rst_n low mid-cycle.
- Response: out_valid[0]=0 immediately; after release, FIFO is empty and a new beat routes normally.
REQ-038 Test 6, performance counters (FABRIC_TAG_DEMUX_PERF_EN defined).
- Stimulus: 5 beats to port 0 and 2 dropped beats.
- Response: perf_out_count[0]=5 and perf_drop_count=2.

Source files
------------

// File: rtl/fabric_tag_demux_pkg.sv
// Shared fabric definitions for the tag demultiplexer: error codes and FIFO geometry.
package fabric_tag_demux_pkg;

  typedef enum logic [15:0] {
    ERR_NONE              = 16'h0000,
    RT_TAG_DEMUX_RANGE    = 16'h0A01,
    RT_TAG_DEMUX_DISABLED = 16'h0A02
  } err_code_e;

  localparam int FIFO_DEPTH     = 2;
  localparam int PERF_CNT_WIDTH = 32;

  // Out-of-range takes priority because the enable bit of a non-existent port is meaningless.
  function automatic err_code_e classify_drop(input logic in_range);
    return in_range ? RT_TAG_DEMUX_DISABLED : RT_TAG_DEMUX_RANGE;
  endfunction

endpackage

// File: rtl/fabric_tag_demux_fifo.sv
// Two-entry per-output FIFO: 1-bit pointers, 2-bit occupancy, full taken from registered state.
module fabric_tag_demux_fifo
  import fabric_tag_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop_ready,
  output logic                  o_valid,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  // A pop never frees space for a push in the same cycle: full is the registered view.
  assign w_push  = i_push && !o_full;
  assign w_pop   = o_valid && i_pop_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_head  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/fabric_tag_demux.sv
// Tag-routed demultiplexer with per-output 2-entry FIFOs and a sticky error report.
// Optional performance counters are built when FABRIC_TAG_DEMUX_PERF_EN is defined.
module fabric_tag_demux
  import fabric_tag_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int NUM_OUT    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUT-1:0]            cfg_data,
  output logic                          error_valid,
  output logic [15:0]                   error_code
`ifdef FABRIC_TAG_DEMUX_PERF_EN
  ,
  output logic [NUM_OUT*PERF_CNT_WIDTH-1:0] perf_out_count,
  output logic [PERF_CNT_WIDTH-1:0]         perf_drop_count
`endif
);

  if (DATA_WIDTH < 1 || TAG_WIDTH < 1 || NUM_OUT < 1 || NUM_OUT > (1 << TAG_WIDTH)) begin : g_param_check
    $fatal(1, "fabric_tag_demux: illegal DATA_WIDTH/TAG_WIDTH/NUM_OUT combination");
  end

  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_value;
  logic [NUM_OUT-1:0]    w_sel;
  logic [NUM_OUT-1:0]    w_full;
  logic [NUM_OUT-1:0]    w_push;
  logic                  w_in_range;
  logic                  w_enabled;
  logic                  w_full_sel;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_err_any;
  err_code_e             w_err_code;
  logic                  r_error_valid;
  err_code_e             r_error_code;

  assign w_tag   = in_data[DATA_WIDTH +: TAG_WIDTH];
  assign w_value = in_data[DATA_WIDTH-1:0];

  // A tag at or above NUM_OUT matches no port, so an empty select doubles as the range check.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_sel[i] = (w_tag == TAG_WIDTH'(i));
    end
  end

  assign w_in_range = |w_sel;
  assign w_enabled  = |(w_sel & cfg_data);
  assign w_full_sel = |(w_sel & w_full);

  // Dropped beats are always consumed so a bad tag cannot deadlock the stream.
  assign in_ready   = rst_n && (!w_enabled || !w_full_sel);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept ? (w_sel & cfg_data) : '0;
  assign w_drop     = w_accept && !w_enabled;

  assign w_err_any  = in_valid && !w_enabled;
  assign w_err_code = classify_drop(w_in_range);

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_port
    fabric_tag_demux_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push[g]),
      .i_push_data (w_value),
      .i_pop_ready (out_ready[g]),
      .o_valid     (out_valid[g]),
      .o_full      (w_full[g]),
      .o_head      (out_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Only the first error is kept; later ones are dropped silently until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error_valid <= 1'b0;
      r_error_code  <= ERR_NONE;
    end else if (!r_error_valid && w_err_any) begin
      r_error_valid <= 1'b1;
      r_error_code  <= w_err_code;
    end
  end

  assign error_valid = r_error_valid;
  assign error_code  = r_error_code;

`ifdef FABRIC_TAG_DEMUX_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] r_perf_out [NUM_OUT];
  logic [PERF_CNT_WIDTH-1:0] r_perf_drop;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_perf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_perf_out[g] <= '0;
      end else if (out_valid[g] && out_ready[g]) begin
        r_perf_out[g] <= r_perf_out[g] + PERF_CNT_WIDTH'(1);
      end
    end
    assign perf_out_count[g*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = r_perf_out[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_drop <= '0;
    end else if (w_drop) begin
      r_perf_drop <= r_perf_drop + PERF_CNT_WIDTH'(1);
    end
  end

  assign perf_drop_count = r_perf_drop;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule
